// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - UART spike-link frame parser writing payload bytes into BRAM
module uart_frame_rx #(
  parameter int         PAYLOAD_LEN = 128,
  parameter int         ADDR_W      = 10,
  parameter logic [7:0] HDR0        = 8'hFA,
  parameter logic [7:0] HDR1        = 8'hF1,
  parameter int         TIMEOUT_CYC = 8191
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic              frame_done,
  output logic              frame_err,
  output logic [7:0]        frame_cnt,
  output logic              busy
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam int CNT_W  = $clog2(PAYLOAD_LEN + 1);

  typedef enum logic [2:0] {HUNT0, HUNT1, PAYLOAD, TAIL0, TAIL1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, base_q;
  logic [CNT_W-1:0]  byte_cnt_q;
  logic [IDLE_W-1:0] idle_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        ram_wdata_q, frame_cnt_q;
  logic              ram_we_q, frame_done_q, frame_err_q, busy_q;

  logic timeout, last_byte, wr_byte, good_frame, abort_frame;

  // A byte arriving in the same cycle as the limit wins over the timeout.
  assign timeout     = (state_q != HUNT0) && !rx_valid && (idle_q == IDLE_W'(TIMEOUT_CYC));
  assign last_byte   = (byte_cnt_q == CNT_W'(PAYLOAD_LEN - 1));
  assign wr_byte     = rx_valid && (state_q == PAYLOAD);
  assign good_frame  = rx_valid && (state_q == TAIL1) && (rx_data == HDR0);
  // Silence in HUNT1 is not an error: nothing has been written yet.
  assign abort_frame = (timeout && (state_q != HUNT1)) ||
                       (rx_valid && (state_q == TAIL0) && (rx_data != HDR1)) ||
                       (rx_valid && (state_q == TAIL1) && (rx_data != HDR0));

  // Next-state decode; transitions happen only on a byte or on the idle timeout.
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = HUNT0;
    end else if (rx_valid) begin
      case (state_q)
        HUNT0:   if (rx_data == HDR0) state_d = HUNT1;
        HUNT1: begin
          if (rx_data == HDR1)      state_d = PAYLOAD;
          else if (rx_data != HDR0) state_d = HUNT0;
        end
        PAYLOAD: if (last_byte) state_d = TAIL0;
        TAIL0: begin
          if (rx_data == HDR1)      state_d = TAIL1;
          else if (rx_data == HDR0) state_d = HUNT1;
          else                      state_d = HUNT0;
        end
        TAIL1:   state_d = HUNT0;
        default: state_d = HUNT0;
      endcase
    end
  end

  // Frame FSM with pointers, idle counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT0;
      wptr_q       <= '0;
      base_q       <= '0;
      byte_cnt_q   <= '0;
      idle_q       <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_we_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_cnt_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= (state_d != HUNT0);
      ram_we_q     <= wr_byte;
      frame_done_q <= good_frame;
      frame_err_q  <= abort_frame;

      if (state_d == HUNT0 || rx_valid) idle_q <= '0;
      else                              idle_q <= idle_q + IDLE_W'(1);

      if (rx_valid && state_q == HUNT1 && rx_data == HDR1) byte_cnt_q <= '0;
      else if (wr_byte)                                    byte_cnt_q <= byte_cnt_q + CNT_W'(1);

      // ram_addr keeps the last written address after a rewind.
      if (wr_byte) begin
        ram_addr_q  <= wptr_q;
        ram_wdata_q <= rx_data;
        wptr_q      <= wptr_q + ADDR_W'(1);
      end else if (abort_frame) begin
        wptr_q      <= base_q;
      end

      if (good_frame) begin
        base_q      <= wptr_q;
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_we     = ram_we_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = busy_q;

endmodule
